// File: rtl/aes_decrypt.sv
// Iterative AES-128 decryption core: forward key expansion to k10, then inverse rounds with on-the-fly key reversal.
// Optional key cache (skips expansion on a repeated key) enabled by defining AES_DEC_KEYCACHE_EN.
module aes_decrypt #(
  parameter int NR       = 10,
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [127:0]        din,
  input  logic [KEY_BITS-1:0] keyin,
  output logic [127:0]        dout,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE,
    KEY_EXPAND,
    INIT_ADD,
    INV_SHIFT,
    INV_SUB,
    KEY_ADD,
    INV_MIX,
    DONE
  } fsm_t;

  fsm_t         fsm, fsm_nxt;
  logic [127:0] blk, blk_nxt;
  logic [127:0] key, key_nxt;
  logic [3:0]   rc, rc_nxt;
  logic [3:0]   round, round_nxt;
  logic         busy_nxt, done_nxt;

`ifdef AES_DEC_KEYCACHE_EN
  logic [127:0] key_cap, key_cap_nxt;
  logic [127:0] k10_cap, k10_cap_nxt;
  logic [127:0] cache_key, cache_key_nxt;
  logic [127:0] cache_k10, cache_k10_nxt;
  logic         cache_vld, cache_vld_nxt;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gmul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] fwd_sched(input logic [127:0] k, input logic [7:0] rcv);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rcv, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_sched(input logic [127:0] k, input logic [7:0] rcv);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot_word(w3) ^ {rcv, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // Byte n sits at bits [127-8n -: 8]; row = n%4, column = n/4
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      int r;
      int c;
      int src;
      r   = n % 4;
      c   = n / 4;
      src = r + 4 * ((c - r + 4) % 4);
      o[127-8*n -: 8] = s[127-8*src -: 8];
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm   <= IDLE;
      blk   <= '0;
      key   <= '0;
      rc    <= '0;
      round <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef AES_DEC_KEYCACHE_EN
      key_cap   <= '0;
      k10_cap   <= '0;
      cache_key <= '0;
      cache_k10 <= '0;
      cache_vld <= 1'b0;
`endif
    end else begin
      fsm   <= fsm_nxt;
      blk   <= blk_nxt;
      key   <= key_nxt;
      rc    <= rc_nxt;
      round <= round_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
`ifdef AES_DEC_KEYCACHE_EN
      key_cap   <= key_cap_nxt;
      k10_cap   <= k10_cap_nxt;
      cache_key <= cache_key_nxt;
      cache_k10 <= cache_k10_nxt;
      cache_vld <= cache_vld_nxt;
`endif
    end
  end

  always_comb begin
    fsm_nxt   = fsm;
    blk_nxt   = blk;
    key_nxt   = key;
    rc_nxt    = rc;
    round_nxt = round;
    busy_nxt  = busy;
    done_nxt  = done;
`ifdef AES_DEC_KEYCACHE_EN
    key_cap_nxt   = key_cap;
    k10_cap_nxt   = k10_cap;
    cache_key_nxt = cache_key;
    cache_k10_nxt = cache_k10;
    cache_vld_nxt = cache_vld;
`endif
    case (fsm)
      IDLE, DONE: begin
        if (start) begin
          blk_nxt  = din;
          key_nxt  = keyin;
          rc_nxt   = 4'd1;
          busy_nxt = 1'b1;
          done_nxt = 1'b0;
          fsm_nxt  = KEY_EXPAND;
`ifdef AES_DEC_KEYCACHE_EN
          key_cap_nxt = keyin;
          if (cache_vld && (keyin == cache_key)) begin
            key_nxt = cache_k10;
            fsm_nxt = INIT_ADD;
          end
`endif
        end
      end
      KEY_EXPAND: begin
        key_nxt = fwd_sched(key, rcon(rc));
        rc_nxt  = rc + 4'd1;
        if (rc == 4'd10) fsm_nxt = INIT_ADD;
      end
      INIT_ADD: begin
        blk_nxt   = blk ^ key;
        round_nxt = 4'(NR - 1);
        fsm_nxt   = INV_SHIFT;
`ifdef AES_DEC_KEYCACHE_EN
        k10_cap_nxt = key;
`endif
      end
      INV_SHIFT: begin
        blk_nxt = inv_shift_rows(blk);
        fsm_nxt = INV_SUB;
      end
      // Round key k(round) is recovered from k(round+1) while the S-box step runs
      INV_SUB: begin
        blk_nxt = inv_sub_bytes(blk);
        key_nxt = inv_sched(key, rcon(round + 4'd1));
        fsm_nxt = KEY_ADD;
      end
      KEY_ADD: begin
        blk_nxt = blk ^ key;
        if (round == 4'd0) begin
          fsm_nxt  = DONE;
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
`ifdef AES_DEC_KEYCACHE_EN
          cache_key_nxt = key_cap;
          cache_k10_nxt = k10_cap;
          cache_vld_nxt = 1'b1;
`endif
        end else begin
          fsm_nxt = INV_MIX;
        end
      end
      INV_MIX: begin
        blk_nxt   = inv_mix(blk);
        round_nxt = round - 4'd1;
        fsm_nxt   = INV_SHIFT;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  assign dout = blk;

endmodule

// File: tb/tb_aes_decrypt.sv
// Self-checking bench for aes_decrypt: FIPS-197 vectors plus randomized ops against a table-driven AES model.
// Latency expectations follow AES_DEC_KEYCACHE_EN when it is defined for the build.
module tb_aes_decrypt;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] din;
  logic [127:0] keyin;
  logic [127:0] dout;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sbox_t     [256];
  logic [7:0]   inv_sbox_t [256];
  logic [7:0]   rcon_t     [10];
  logic [127:0] tb_cache_key = '0;
  bit           tb_cache_vld = 1'b0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_decrypt dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .keyin (keyin),
    .dout  (dout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // S-box tables derived by brute-force inverse search plus the bitwise affine map
  task automatic build_tables();
    logic [7:0] c;
    logic [7:0] r;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (tb_gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[a]     = s;
      inv_sbox_t[s] = 8'(a);
    end
    r = 8'h01;
    for (int i = 0; i < 10; i++) begin
      rcon_t[i] = r;
      r = tb_gmul(r, 8'h02);
    end
  endtask

  function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic [127:0] k);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  base [4];
    logic [127:0] res;
    base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] x;
      x = w[i-1];
      if (i % 4 == 0)
        x = {sbox_t[x[23:16]] ^ rcon_t[i/4-1], sbox_t[x[15:8]], sbox_t[x[7:0]], sbox_t[x[31:24]]};
      w[i] = w[i-4] ^ x;
    end
    for (int n = 0; n < 16; n++) s[n] = ct[127-8*n -: 8] ^ w[40 + n/4][31-8*(n%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int n = 0; n < 16; n++) t[n] = s[(n%4) + 4*(((n/4) - (n%4) + 4) % 4)];
      for (int n = 0; n < 16; n++) s[n] = inv_sbox_t[t[n]] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int i = 0; i < 4; i++) begin
            t[4*c+i] = 8'h00;
            for (int j = 0; j < 4; j++) t[4*c+i] ^= tb_gmul(base[(j-i+4)%4], s[4*c+j]);
          end
        for (int n = 0; n < 16; n++) s[n] = t[n];
      end
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  function automatic int expected_latency(input logic [127:0] k);
`ifdef AES_DEC_KEYCACHE_EN
    return (tb_cache_vld && (k == tb_cache_key)) ? 40 : 50;
`else
    return (k === k) ? 50 : 50;
`endif
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] k);
    din   = ct;
    keyin = k;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // mode 0: quiet inputs; 1: extra start pulses at edges 5/20/49; 2: din/keyin scrambled every cycle
  task automatic run_op(input string name, input logic [127:0] ct, input logic [127:0] k, input int mode);
    logic [127:0] exp_pt;
    int exp_lat;
    int edges;
    int busy_cnt;
    bit got_done;
    exp_pt  = model_decrypt(ct, k);
    exp_lat = expected_latency(k);
    applyStimulus(ct, k);
    checkOutput({name, "_accept_busy"}, 128'(busy), 128'(1));
    checkOutput({name, "_accept_done"}, 128'(done), 128'(0));
    busy_cnt = busy ? 1 : 0;
    edges    = 0;
    got_done = 1'b0;
    while (!got_done && edges < 100) begin
      start = 1'b0;
      if (mode == 1 && (edges + 1 == 5 || edges + 1 == 20 || edges + 1 == 49) && edges + 1 < exp_lat) begin
        start = 1'b1;
        din   = rand128();
      end
      if (mode == 2) begin
        din   = rand128();
        keyin = rand128();
      end
      @(posedge clk);
      #1;
      edges++;
      if (done) got_done = 1'b1;
      else if (busy) busy_cnt++;
    end
    start = 1'b0;
    checkOutput({name, "_done_seen"}, 128'(got_done), 128'(1));
    checkOutput({name, "_latency"}, 128'(edges), 128'(exp_lat));
    checkOutput({name, "_busy_cycles"}, 128'(busy_cnt), 128'(exp_lat));
    checkOutput({name, "_busy_at_done"}, 128'(busy), 128'(0));
    checkOutput({name, "_dout"}, dout, exp_pt);
    if (got_done) begin
      tb_cache_key = k;
      tb_cache_vld = 1'b1;
    end
  endtask

  initial begin
    logic [127:0] k_prev;
    rst   = 1'b0;
    start = 1'b0;
    din   = '0;
    keyin = '0;
    build_tables();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_dout", dout, 128'h0);
    checkOutput("reset_done", 128'(done), 128'(0));
    checkOutput("reset_busy", 128'(busy), 128'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_op("fips_c1", C1_CT, C1_KEY, 0);
    checkOutput("fips_c1_const", dout, C1_PT);
    run_op("fips_b", B_CT, B_KEY, 0);
    checkOutput("fips_b_const", dout, B_PT);
    run_op("same_key", rand128(), B_KEY, 0);
    run_op("ignored_start", C1_CT, C1_KEY, 1);
    checkOutput("ignored_start_const", dout, C1_PT);

    applyStimulus(rand128(), rand128());
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midop_reset_dout", dout, 128'h0);
    checkOutput("midop_reset_done", 128'(done), 128'(0));
    checkOutput("midop_reset_busy", 128'(busy), 128'(0));
    rst = 1'b1;
    tb_cache_vld = 1'b0;
    @(posedge clk);
    #1;
    run_op("after_reset", rand128(), rand128(), 0);

    k_prev = rand128();
    for (int i = 0; i < 4; i++) begin
      if (i != 2) k_prev = rand128();
      run_op($sformatf("rand%0d", i), rand128(), k_prev, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
